pcs_tx_gearbox_feed: RTL

Sequencing stage directly upstream of the 64b/66b TX gearbox. Accepts 66-bit blocks (2-bit sync header + payload) from the scrambler over a valid/ready handshake. Slices each block into DATA_W-wide beats and drives the gearbox's sequence count, sync header and data inputs. Inserts the periodic pause cycle that lets the gearbox flush its accumulated header bits, and back-pressures the scrambler during that cycle.

---
 rtl/pcs_pkg.sv | 20 ++
 rtl/pcs_tx_seq_cnt.sv | 55 +++++
 rtl/pcs_tx_gearbox_feed.sv | 117 +++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync headers, the idle control block and small sizing helpers.
package pcs_pkg;

  localparam logic [1:0] HEAD_DATA = 2'b01;
  localparam logic [1:0] HEAD_CTRL = 2'b10;

  typedef struct packed {
    logic [1:0]  head;
    logic [63:0] data;
  } pcs_block_t;

  // All-idle control block, unscrambled.
  localparam pcs_block_t IDLE_BLOCK = '{head: HEAD_CTRL, data: 64'h1E};

  // Counter width for an index that spans 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcs_tx_seq_cnt.sv
// Gearbox sequence/beat counter: CNT_N beats per sequence step, one pause cycle at SEQ_FULL.
module pcs_tx_seq_cnt
  import pcs_pkg::*;
#(
  parameter int unsigned CNT_N    = 1,
  parameter int unsigned SEQ_FULL = 32,
  parameter int unsigned SEQ_W    = 6,
  parameter int unsigned BEAT_W   = idx_width(CNT_N)
) (
  input  logic              clk,
  input  logic              nreset,
  output logic [SEQ_W-1:0]  seq_o,
  output logic [BEAT_W-1:0] beat_next_o,
  output logic              last_beat_o,
  output logic              pause_o,
  output logic              pause_next_o
);

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pause, last_beat, pause_next;

  always_comb begin
    pause      = (seq_q == SEQ_W'(SEQ_FULL));
    last_beat  = !pause && (beat_q == BEAT_W'(CNT_N - 1));
    pause_next = last_beat && (seq_q == SEQ_W'(SEQ_FULL - 1));
    seq_d      = seq_q;
    beat_d     = beat_q;
    if (pause) begin
      seq_d = '0;
    end else if (last_beat) begin
      seq_d  = seq_q + 1'b1;
      beat_d = '0;
    end else begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq_q  <= '0;
      beat_q <= '0;
    end else begin
      seq_q  <= seq_d;
      beat_q <= beat_d;
    end
  end

  assign seq_o        = seq_q;
  assign beat_next_o  = beat_d;
  assign last_beat_o  = last_beat;
  assign pause_o      = pause;
  assign pause_next_o = pause_next;

endmodule

// File: rtl/pcs_tx_gearbox_feed.sv
// Feeds 66-bit blocks to the TX gearbox as DATA_W beats with periodic pause cycles.
// Optional PCS_TX_IDLE_INSERT_EN: underflowed block slots carry a full idle control block.
module pcs_tx_gearbox_feed
  import pcs_pkg::*;
#(
  parameter int unsigned BLOCK_DATA_W = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned HEAD_W       = 2,
  parameter int unsigned SEQ_FULL     = DATA_W / HEAD_W,
  parameter int unsigned SEQ_W        = $clog2(DATA_W / HEAD_W + 1)
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [HEAD_W-1:0]       in_head_i,
  input  logic [BLOCK_DATA_W-1:0] in_data_i,
  output logic [SEQ_W-1:0]        seq_o,
  output logic [HEAD_W-1:0]       head_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    underflow_o
);

  localparam int unsigned CNT_N  = BLOCK_DATA_W / DATA_W;
  localparam int unsigned BEAT_W = idx_width(CNT_N);

  logic [BEAT_W-1:0]       beat_next;
  logic                    last_beat, pause, pause_next;
  logic                    ready, accept;

  logic                    blk_v_q, blk_v_d;
  logic [HEAD_W-1:0]       blk_head_q, blk_head_d;
  logic [BLOCK_DATA_W-1:0] blk_data_q, blk_data_d;
  logic [HEAD_W-1:0]       head_q, head_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    underflow_q, underflow_d;

  pcs_tx_seq_cnt #(
    .CNT_N    (CNT_N),
    .SEQ_FULL (SEQ_FULL),
    .SEQ_W    (SEQ_W),
    .BEAT_W   (BEAT_W)
  ) u_seq_cnt (
    .clk          (clk),
    .nreset       (nreset),
    .seq_o        (seq_o),
    .beat_next_o  (beat_next),
    .last_beat_o  (last_beat),
    .pause_o      (pause),
    .pause_next_o (pause_next)
  );

`ifdef PCS_TX_IDLE_INSERT_EN
  // Blocks only enter on a slot boundary, so an idle slot is never cut short.
  assign ready = (last_beat | pause) & ~pause_next;
`else
  // The register is always empty in a pause cycle, so including pause changes nothing.
  assign ready = (last_beat | pause | ~blk_v_q) & ~pause_next;
`endif
  assign accept = in_valid_i & ready;

  always_comb begin
    blk_v_d    = blk_v_q;
    blk_head_d = blk_head_q;
    blk_data_d = blk_data_q;
    if (accept) begin
      blk_v_d    = 1'b1;
      blk_head_d = in_head_i;
      blk_data_d = in_data_i;
    end else if (last_beat) begin
      blk_v_d = 1'b0;
    end
  end

  // Outputs are registered from next state so they line up with seq_o.
  always_comb begin
    head_d      = '0;
    data_d      = '0;
    underflow_d = 1'b0;
    if (!pause_next) begin
      if (blk_v_d) begin
        head_d = blk_head_d;
        data_d = DATA_W'(blk_data_d >> (DATA_W * 32'(beat_next)));
      end else begin
        underflow_d = 1'b1;
`ifdef PCS_TX_IDLE_INSERT_EN
        head_d = HEAD_W'(IDLE_BLOCK.head);
        data_d = DATA_W'(BLOCK_DATA_W'(IDLE_BLOCK.data) >> (DATA_W * 32'(beat_next)));
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      blk_v_q     <= 1'b0;
      blk_head_q  <= '0;
      blk_data_q  <= '0;
      head_q      <= '0;
      data_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      blk_v_q     <= blk_v_d;
      blk_head_q  <= blk_head_d;
      blk_data_q  <= blk_data_d;
      head_q      <= head_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
    end
  end

  assign in_ready_o  = ready;
  assign head_o      = head_q;
  assign data_o      = data_q;
  assign underflow_o = underflow_q;

endmodule
